fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 16'h0000, first fetch address after reset.
REQ-002 Parameter: NOP_INSTR, default 16'h1000, bubble instruction; opcode 4'b0001 decodes to all-zero controls.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  16  byte address of the requested instruction.
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-008 imem_rdata  input  16  fetched instruction word.
REQ-009 instr  output  16  registered instruction to decode.
REQ-010 op  output  4  instr[15:12], the main-decoder opcode.
REQ-011 instr_valid  output  1  instr/op/pc_out hold a real instruction.
REQ-012 pc_out  output  16  address of instr.
REQ-013 pcplus2  output  16  pc_out + 2, modulo 2^16.
REQ-014 stall  input  1  decode cannot accept; hold current instruction.
REQ-015 redirect  input  1  branch/jump taken; refetch from redirect_pc.
REQ-016 redirect_pc  input  16  redirect target; bit 0 is ignored and forced to 0.

Function
REQ-017 The FSM SHALL have states FETCH, VALID and DRAIN.
REQ-018 In FETCH: imem_req=1 and imem_addr=pc, both held stable until imem_ack.
REQ-019 FETCH with imem_ack and no redirect: instr<=imem_rdata, pc_out<=pc, next state VALID; instr_valid rises on the following cycle (one-cycle fetch latency after ack).
REQ-020 In VALID: imem_req=0 and instr_valid=1; with stall=1, instr, op and pc_out are held unchanged.
REQ-021 VALID with stall=0 and no redirect: pc<=pc+2 (wrapping 16'hFFFE to 16'h0000), instr<=NOP_INSTR, instr_valid<=0, next state FETCH.
REQ-022 Redirect in VALID: pc<=redirect_pc, instruction dropped, instr_valid<=0, next state FETCH; this overrides stall.
REQ-023 Redirect in FETCH with imem_ack in the same cycle: returned data is discarded, pc<=redirect_pc, remain in FETCH.
REQ-024 Redirect in FETCH without imem_ack: pending target<=redirect_pc, next state DRAIN.
REQ-025 In DRAIN: imem_req stays 1 at the old address; a further redirect overwrites the pending target (latest wins).
REQ-026 DRAIN on imem_ack: data is discarded, pc<=pending target, next state FETCH.
REQ-027 If DRAIN receives imem_ack and redirect together, pc SHALL take the new redirect_pc.
REQ-028 Whenever instr_valid=0, instr=NOP_INSTR and op=4'b0001.
REQ-029 Discarded memory data SHALL never appear on instr.
REQ-030 pcplus2 SHALL be combinational from pc_out.

Reset
REQ-031 On reset assertion, independent of clk: state=FETCH, pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, pc_out=RESET_PC, pending target=RESET_PC.
REQ-032 During reset, imem_req SHALL be 0.
REQ-033 imem_req SHALL assert on the first clock edge after reset deasserts.
REQ-034 Reset mid-transaction (FETCH or DRAIN) SHALL abandon the outstanding request.
REQ-035 The memory side SHALL tolerate an unacknowledged request being dropped.

Structure
REQ-036 A shared CPU package SHALL hold the state encoding, NOP_INSTR, the opcode field position [15:12] and the instruction/address width 16.
REQ-037 The shared package SHALL hold the opcode constants 0000, 0100, 1011, 1111, 1000, 0010 and 0001, shared with the main decoder.
REQ-038 One sub-module, pc_reg (reset-loadable 16-bit register with enable), SHALL be used for pc, pc_out and pending target.

Verification
REQ-039 Reset release, ack on the 2nd request cycle with rdata 16'h4123 -> imem_addr 0x0000, then instr 16'h4123, op 4'b0100, pc_out 0x0000, pcplus2 0x0002.
REQ-040 Instruction valid, stall=1 for 3 cycles -> instr/pc_out unchanged and imem_req=0; after release, next imem_addr = 0x0002.
REQ-041 Redirect to 0x0040 in FETCH, ack 2 cycles later, then ack again -> first data never valid, second request at 0x0040.
REQ-042 Redirects to 0x0040 then 0x0080 while in DRAIN -> next fetch at 0x0080.
REQ-043 pc=0xFFFE accepted with stall=0 -> next imem_addr 0x0000.
REQ-044 Reset asserted while FETCH waits for ack -> imem_req=0 immediately, instr_valid=0, op 4'b0001; restart fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the fetch unit and the main decoder.
// Holds the datapath width, opcode field position, opcode constants,
// the bubble instruction and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam int unsigned XLEN   = 16;
  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned OP_W   = OP_MSB - OP_LSB + 1;

  // Main-decoder opcodes
  localparam logic [OP_W-1:0] OP_0000 = 4'b0000;
  localparam logic [OP_W-1:0] OP_0100 = 4'b0100;
  localparam logic [OP_W-1:0] OP_1011 = 4'b1011;
  localparam logic [OP_W-1:0] OP_1111 = 4'b1111;
  localparam logic [OP_W-1:0] OP_1000 = 4'b1000;
  localparam logic [OP_W-1:0] OP_0010 = 4'b0010;
  localparam logic [OP_W-1:0] OP_NOP  = 4'b0001;

  // Bubble: opcode 0001 decodes to all-zero controls
  localparam logic [XLEN-1:0] NOP_INSTR = 16'h1000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_VALID = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Reset-loadable address register with load enable.
// Ports: clk, reset (async, active-high), i_en (load), i_d (next value),
//        o_q (current value; returns to RESET_VAL on reset).
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_en,
  input  logic [XLEN-1:0] i_d,
  output logic [XLEN-1:0] o_q
);

  logic [XLEN-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= RESET_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory read at a time,
// presents the returned word to decode with its address, honours decode
// stalls and branch redirects, and drops data belonging to a request that
// was overtaken by a redirect.
// Ports: clk, reset (async, active-high);
//        imem_req/imem_addr out, imem_ack/imem_rdata in (memory side);
//        instr/op/instr_valid/pc_out/pcplus2 out (decode side);
//        stall, redirect, redirect_pc in (pipeline control).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 16'h0000,
  parameter logic [XLEN-1:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [OP_W-1:0] op,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pcplus2,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_e r_state, w_state_nxt;

  logic            r_req;
  logic [XLEN-1:0] r_instr;
  logic            r_valid;

  logic [XLEN-1:0] w_pc, w_pc_d;
  logic            w_pc_en;
  logic [XLEN-1:0] w_pc_out;
  logic            w_pc_out_en;
  logic [XLEN-1:0] w_pend;
  logic            w_pend_en;
  logic [XLEN-1:0] w_redir_pc;
  logic [XLEN-1:0] w_instr_d;
  logic            w_valid_d;
  logic            w_req_d;

  // Instructions are halfword aligned
  assign w_redir_pc = redirect_pc & ~XLEN'(1);

  pc_reg #(.RESET_VAL(RESET_PC)) u_pc (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_pc_en),
    .i_d   (w_pc_d),
    .o_q   (w_pc)
  );

  pc_reg #(.RESET_VAL(RESET_PC)) u_pc_out (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_pc_out_en),
    .i_d   (w_pc),
    .o_q   (w_pc_out)
  );

  // Target captured while an overtaken request is still in flight
  pc_reg #(.RESET_VAL(RESET_PC)) u_pend (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_pend_en),
    .i_d   (w_redir_pc),
    .o_q   (w_pend)
  );

  // State, request and decode-side registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_req   <= 1'b0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_d;
      r_instr <= w_instr_d;
      r_valid <= w_valid_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt = r_state;
    w_pc_en     = 1'b0;
    w_pc_d      = w_pc;
    w_pc_out_en = 1'b0;
    w_pend_en   = 1'b0;
    w_instr_d   = r_instr;
    w_valid_d   = r_valid;

    unique case (r_state)
      ST_FETCH: begin
        // r_req is low only for the first cycle after reset; no ack can be owed then
        if (r_req && imem_ack) begin
          if (redirect) begin
            w_pc_en = 1'b1;
            w_pc_d  = w_redir_pc;
          end else begin
            w_instr_d   = imem_rdata;
            w_valid_d   = 1'b1;
            w_pc_out_en = 1'b1;
            w_state_nxt = ST_VALID;
          end
        end else if (redirect) begin
          if (r_req) begin
            w_pend_en   = 1'b1;
            w_state_nxt = ST_DRAIN;
          end else begin
            w_pc_en = 1'b1;
            w_pc_d  = w_redir_pc;
          end
        end
      end

      ST_VALID: begin
        if (redirect || !stall) begin
          w_pc_en     = 1'b1;
          w_pc_d      = redirect ? w_redir_pc : w_pc + XLEN'(2);
          w_instr_d   = NOP_INSTR;
          w_valid_d   = 1'b0;
          w_state_nxt = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        // Old request still owes an ack; keep it stable and discard its data
        if (imem_ack) begin
          w_pc_en     = 1'b1;
          w_pc_d      = redirect ? w_redir_pc : w_pend;
          w_state_nxt = ST_FETCH;
        end else if (redirect) begin
          w_pend_en = 1'b1;
        end
      end

      default: begin
        w_instr_d   = NOP_INSTR;
        w_valid_d   = 1'b0;
        w_state_nxt = ST_FETCH;
      end
    endcase

    w_req_d = (w_state_nxt != ST_VALID);
  end

  assign imem_req    = r_req;
  assign imem_addr   = w_pc;
  assign instr       = r_instr;
  assign op          = r_instr[OP_MSB:OP_LSB];
  assign instr_valid = r_valid;
  assign pc_out      = w_pc_out;
  assign pcplus2     = w_pc_out + XLEN'(2);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [3:0]  op;
  logic        instr_valid;
  logic [15:0] pc_out;
  logic [15:0] pcplus2;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(16'h1000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .op          (op),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .pcplus2     (pcplus2),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks every decode/memory-side output at once
  task automatic chk_all(input string tag, input logic req, input logic [15:0] addr,
                         input logic vld, input logic [15:0] ins, input logic [15:0] pco);
    chk({tag, ".req"},   16'(imem_req), 16'(req));
    chk({tag, ".addr"},  imem_addr, addr);
    chk({tag, ".valid"}, 16'(instr_valid), 16'(vld));
    chk({tag, ".instr"}, instr, ins);
    chk({tag, ".op"},    16'(op), 16'(ins[15:12]));
    chk({tag, ".pcout"}, pc_out, pco);
    chk({tag, ".pc2"},   pcplus2, pco + 16'd2);
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0000;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    tick(); tick();
    chk_all("reset", 1'b0, 16'h0000, 1'b0, 16'h1000, 16'h0000);

    // Request rises on the first edge after release; ack on 2nd request cycle
    reset = 1'b0;
    tick();
    chk_all("req_rise", 1'b1, 16'h0000, 1'b0, 16'h1000, 16'h0000);
    tick();
    chk_all("req_hold", 1'b1, 16'h0000, 1'b0, 16'h1000, 16'h0000);
    imem_ack = 1'b1; imem_rdata = 16'h4123;
    tick();
    imem_ack = 1'b0;
    chk_all("first", 1'b0, 16'h0000, 1'b1, 16'h4123, 16'h0000);
    chk("first.op4", 16'(op), 16'h0004);

    // Stall holds the instruction
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("stall", 1'b0, 16'h0000, 1'b1, 16'h4123, 16'h0000);
    end
    stall = 1'b0;
    tick();
    chk_all("advance", 1'b1, 16'h0002, 1'b0, 16'h1000, 16'h0000);

    // Redirect in FETCH without ack: drain, discard, refetch at target
    redirect = 1'b1; redirect_pc = 16'h0041;
    tick();
    redirect = 1'b0;
    chk_all("drain", 1'b1, 16'h0002, 1'b0, 16'h1000, 16'h0000);
    tick();
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    tick();
    imem_ack = 1'b0;
    chk_all("drained", 1'b1, 16'h0040, 1'b0, 16'h1000, 16'h0000);
    imem_ack = 1'b1; imem_rdata = 16'h2ABC;
    tick();
    imem_ack = 1'b0;
    chk_all("tgt40", 1'b0, 16'h0040, 1'b1, 16'h2ABC, 16'h0040);
    tick();
    chk_all("adv42", 1'b1, 16'h0042, 1'b0, 16'h1000, 16'h0040);

    // Two redirects while draining: the latest wins
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect_pc = 16'h0080;
    tick();
    redirect = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    tick();
    imem_ack = 1'b0;
    chk_all("latest", 1'b1, 16'h0080, 1'b0, 16'h1000, 16'h0040);

    // Redirect coinciding with ack in DRAIN takes the new target
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect_pc = 16'h0200; imem_ack = 1'b1; imem_rdata = 16'h5555;
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    chk_all("drain_ack_redir", 1'b1, 16'h0200, 1'b0, 16'h1000, 16'h0040);

    // Redirect with ack in FETCH: data dropped, stay in FETCH at target
    redirect = 1'b1; redirect_pc = 16'hFFFE; imem_ack = 1'b1; imem_rdata = 16'h7777;
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    chk_all("fetch_ack_redir", 1'b1, 16'hFFFE, 1'b0, 16'h1000, 16'h0040);
    imem_ack = 1'b1; imem_rdata = 16'h8005;
    tick();
    imem_ack = 1'b0;
    chk_all("top", 1'b0, 16'hFFFE, 1'b1, 16'h8005, 16'hFFFE);
    chk("top.pc2wrap", pcplus2, 16'h0000);
    tick();
    chk_all("wrap", 1'b1, 16'h0000, 1'b0, 16'h1000, 16'hFFFE);

    // Redirect overrides stall in VALID
    imem_ack = 1'b1; imem_rdata = 16'hB00F;
    tick();
    imem_ack = 1'b0;
    chk_all("v0", 1'b0, 16'h0000, 1'b1, 16'hB00F, 16'h0000);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0010;
    tick();
    stall = 1'b0; redirect = 1'b0;
    chk_all("redir_over_stall", 1'b1, 16'h0010, 1'b0, 16'h1000, 16'h0000);

    // Reset while FETCH awaits ack
    tick();
    reset = 1'b1;
    #1;
    chk_all("midreset", 1'b0, 16'h0000, 1'b0, 16'h1000, 16'h0000);
    tick();
    reset = 1'b0;
    tick();
    chk_all("restart", 1'b1, 16'h0000, 1'b0, 16'h1000, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
